// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU. Takes the 4-bit control code from the ALU control
//   decoder and two operands. It returns a registered result through a
//   valid/ready handshake.
//   Single-cycle ops complete at the accepting edge. MUL (4'b0011) runs on an
//   iterative shift-add multiplier and holds busy_o high while it runs, so the
//   core stalls on MUL instead of needing a combinational multiplier.
//
//   Optional build macro: ALU_MUL_EARLY_EXIT_EN
//     defined   - MUL finishes as soon as the remaining multiplier bits are all
//                 zero (latency = max(1, msb index of B + 1) cycles)
//     undefined - MUL always takes MUL_ITERS cycles
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   valid_i    in   1     op request, sampled only while ready_o=1
//   alu_ctrl_i in   4     control code from the ALU control decoder
//   op_a_i     in   XLEN  operand A (rs1)
//   op_b_i     in   XLEN  operand B (rs2 or immediate)
//   flush_i    in   1     synchronous abort of any in-flight op
//   ready_o    out  1     idle, can accept
//   busy_o     out  1     MUL in flight (stall request)
//   done_o     out  1     one-cycle pulse: result_o/zero_o just updated
//   result_o   out  XLEN  registered result, held until next completion
//   zero_o     out  1     registered (result == 0)
//
// FSM states:
//   state | meaning
//   IDLE  | ready; single-cycle ops complete here, MUL accept leaves
//   MUL   | shift-add iterations in progress, new requests ignored
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = $clog2(MUL_ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0]  alu_res;
  logic [XLEN-1:0]  acc_sum;
  logic [XLEN-1:0]  mplier_shift;
  logic             mul_last;

  logic             alu_done;
  logic             load_mul;
  logic             mul_step;
  logic             mul_done;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU operations
  // ---------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  assign shamt = op_b_i[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_i)
      OP_AND:  alu_res = op_a_i & op_b_i;
      OP_OR:   alu_res = op_a_i | op_b_i;
      OP_ADD:  alu_res = op_a_i + op_b_i;
      OP_SUB:  alu_res = op_a_i - op_b_i;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      OP_SLL:  alu_res = op_a_i << shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add multiplier step. The low product bits do not depend on operand
  // signedness, so one unsigned datapath serves MUL for both interpretations.
  // ---------------------------------------------------------------------------
  assign acc_sum      = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shift = mplier >> 1;

`ifdef ALU_MUL_EARLY_EXIT_EN
  // Once no multiplier bits remain, later iterations would only add zero.
  assign mul_last = (cnt == LAST_CNT) || (mplier_shift == '0);
`else
  assign mul_last = (cnt == LAST_CNT);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    alu_done   = 1'b0;
    load_mul   = 1'b0;
    mul_step   = 1'b0;
    mul_done   = 1'b0;
    // flush wins over both a new request and a pending iteration
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (alu_ctrl_i == OP_MUL) begin
              load_mul   = 1'b1;
              state_next = MUL;
            end else begin
              alu_done = 1'b1;
            end
          end
        end
        MUL: begin
          mul_step = 1'b1;
          if (mul_last) begin
            mul_done   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign busy_o  = (state == MUL);

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        cnt <= '0;
      end else if (alu_done) begin
        result_o <= alu_res;
        zero_o   <= (alu_res == '0);
        done_o   <= 1'b1;
      end else if (load_mul) begin
        acc    <= '0;
        mcand  <= op_a_i;
        mplier <= op_b_i;
        cnt    <= '0;
      end else if (mul_step) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier_shift;
        if (mul_done) begin
          cnt      <= '0;
          result_o <= acc_sum;
          zero_o   <= (acc_sum == '0);
          done_o   <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
